ps2_kbd_ctrl: RTL and testbench

Sequencer sitting between the PS/2 keyboard receiver FIFO and the CPU I/O bus. Drains scan-code bytes through the receiver's active-low read strobe and parses Set-2 sequences (E0 extended prefix, F0 break prefix). Emits one key event per complete sequence through a valid/ack holding register and tracks modifier state. Owns the receiver's read side, so no other logic drives its rdn.

---
 rtl/ps2_kbd_pkg.sv | 14 +
 rtl/ps2_kbd_modtrack.sv | 35 +++
 rtl/ps2_kbd_ctrl.sv | 113 +++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared FSM state type and PS/2 Set-2 scan-code constants.
// Contents: state_t (S_IDLE, S_EXT, S_BRK, S_HOLD) and the prefix, error and modifier codes.
package ps2_kbd_pkg;
    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_HOLD} state_t;
    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;
endpackage

// File: rtl/ps2_kbd_modtrack.sv
// ps2_kbd_modtrack: modifier level tracking and caps-lock toggle, driven by emitted key events.
// Ports: clk, clrn (async active-low reset), i_emit (event strobe), i_code/i_brk/i_ext (event fields),
//        o_mods = {caps_lock, alt, ctrl, shift}.
module ps2_kbd_modtrack
    import ps2_kbd_pkg::*;
(
    input  logic       clk,
    input  logic       clrn,
    input  logic       i_emit,
    input  logic [7:0] i_code,
    input  logic       i_brk,
    input  logic       i_ext,
    output logic [3:0] o_mods
);
    logic r_lshift, r_rshift, r_ctrl, r_alt, r_caps;
    // Shift and caps keys are never E0-prefixed; E0 12 is the fake shift some keys send.
    logic w_plain;
    assign w_plain = i_emit & ~i_ext;
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
            r_ctrl   <= 1'b0;
            r_alt    <= 1'b0;
            r_caps   <= 1'b0;
        end else begin
            if (w_plain && i_code == SC_LSHIFT) r_lshift <= ~i_brk;
            if (w_plain && i_code == SC_RSHIFT) r_rshift <= ~i_brk;
            if (i_emit && i_code == SC_CTRL) r_ctrl <= ~i_brk;
            if (i_emit && i_code == SC_ALT) r_alt <= ~i_brk;
            if (w_plain && !i_brk && i_code == SC_CAPS) r_caps <= ~r_caps;
        end
    end
    assign o_mods = {r_caps, r_alt, r_ctrl, r_lshift | r_rshift};
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: drains the PS/2 receiver FIFO, parses Set-2 E0/F0 sequences into key events.
// Ports: clk, clrn (async active-low reset); receiver side kb_ready, kb_data, kb_overflow, kb_rdn;
//        event side ev_valid, ev_code, ev_brk, ev_ext, ev_ack; mods, err, err_clr.
// Build option: define KBD_REPEAT_FILTER_EN to suppress typematic repeats of the held key.
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int TW             = 18
)(
    input  logic       clk,
    input  logic       clrn,
    input  logic       kb_ready,
    input  logic [7:0] kb_data,
    input  logic       kb_overflow,
    output logic       kb_rdn,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_brk,
    output logic       ev_ext,
    input  logic       ev_ack,
    output logic [3:0] mods,
    output logic       err,
    input  logic       err_clr
);
    state_t        r_state;
    logic [TW-1:0] r_cnt;
    logic          r_ext;
    logic          r_ev_valid, r_ev_brk, r_ev_ext, r_err;
    logic [7:0]    r_ev_code;
    logic          w_fetch, w_e0, w_f0, w_errcode, w_pend, w_tmo;
    logic          w_make, w_brk, w_bad, w_rep, w_emit, w_make_ext;
    // Gating with clrn keeps the strobe idle while reset is held.
    assign w_fetch    = clrn & kb_ready & (r_state != S_HOLD);
    assign kb_rdn     = ~w_fetch;
    assign w_e0       = kb_data == SC_E0;
    assign w_f0       = kb_data == SC_F0;
    assign w_errcode  = (kb_data == SC_ERR0) | (kb_data == SC_ERR1);
    assign w_pend     = (r_state == S_EXT) | (r_state == S_BRK);
    assign w_tmo      = w_pend & ~w_fetch & (r_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_make     = w_fetch & ~w_e0 & ~w_f0 &
                        (((r_state == S_IDLE) & ~w_errcode) | (r_state == S_EXT));
    assign w_brk      = w_fetch & (r_state == S_BRK) & ~w_e0 & ~w_f0;
    assign w_bad      = w_fetch & (r_state == S_BRK) & (w_e0 | w_f0);
    assign w_make_ext = r_state == S_EXT;
    assign w_emit     = w_brk | (w_make & ~w_rep);
`ifdef KBD_REPEAT_FILTER_EN
    logic       r_held_v;
    logic [8:0] r_held;
    assign w_rep = w_make & r_held_v & (r_held == {w_make_ext, kb_data});
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_held_v <= 1'b0;
            r_held   <= '0;
        end else if (w_make && !w_rep) begin
            r_held_v <= 1'b1;
            r_held   <= {w_make_ext, kb_data};
        end else if (w_brk && r_held == {r_ext, kb_data}) begin
            r_held_v <= 1'b0;
        end
    end
`else
    assign w_rep = 1'b0;
`endif
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ext      <= 1'b0;
            r_ev_valid <= 1'b0;
            r_ev_code  <= 8'h00;
            r_ev_brk   <= 1'b0;
            r_ev_ext   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // A set condition in the same cycle as err_clr keeps err high.
            r_err <= (kb_overflow | w_tmo | w_bad) ? 1'b1 : err_clr ? 1'b0 : r_err;
            r_cnt <= (w_pend && !w_fetch && !w_tmo) ? r_cnt + TW'(1) : '0;
            if (w_emit) begin
                r_state    <= S_HOLD;
                r_ev_valid <= 1'b1;
                r_ev_code  <= kb_data;
                r_ev_brk   <= w_brk;
                r_ev_ext   <= w_brk ? r_ext : w_make_ext;
            end else if (w_tmo || w_bad || w_rep) begin
                r_state <= S_IDLE;
            end else if (w_fetch && w_e0 && r_state != S_BRK) begin
                r_state <= S_EXT;
                r_ext   <= 1'b1;
            end else if (w_fetch && w_f0 && r_state != S_BRK) begin
                r_state <= S_BRK;
                r_ext   <= w_make_ext;
            end else if (r_state == S_HOLD && ev_ack) begin
                r_state    <= S_IDLE;
                r_ev_valid <= 1'b0;
            end
        end
    end
    ps2_kbd_modtrack u_modtrack (
        .clk    (clk),
        .clrn   (clrn),
        .i_emit (w_emit),
        .i_code (kb_data),
        .i_brk  (w_brk),
        .i_ext  (w_brk ? r_ext : w_make_ext),
        .o_mods (mods)
    );
    assign ev_valid = r_ev_valid;
    assign ev_code  = r_ev_code;
    assign ev_brk   = r_ev_brk;
    assign ev_ext   = r_ev_ext;
    assign err      = r_err;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: directed self-checking bench for ps2_kbd_ctrl with a queue-modelled receiver FIFO.
module tb_ps2_kbd_ctrl;
    logic       clk = 1'b0, clrn = 1'b0;
    logic       kb_ready = 1'b0, kb_overflow = 1'b0, ev_ack = 1'b0, err_clr = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_rdn, ev_valid, ev_brk, ev_ext, err;
    logic [7:0] ev_code;
    logic [3:0] mods;
    logic [7:0] q[$];
    logic [7:0] dummy;
    logic       rdn_low, last_brk;
    int         checks = 0, errors = 0, pulses = 0, p0, n;

    always #5 clk = ~clk;

    ps2_kbd_ctrl #(.TIMEOUT_CYCLES(100), .TW(18)) dut (
        .clk(clk), .clrn(clrn), .kb_ready(kb_ready), .kb_data(kb_data), .kb_overflow(kb_overflow),
        .kb_rdn(kb_rdn), .ev_valid(ev_valid), .ev_code(ev_code), .ev_brk(ev_brk), .ev_ext(ev_ext),
        .ev_ack(ev_ack), .mods(mods), .err(err), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        kb_ready = q.size() != 0;
        kb_data  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        refresh();
    endtask

    // One clock: strobe sampled mid-cycle, FIFO pops after the edge that consumed the byte.
    task automatic tick();
        @(negedge clk);
        rdn_low = !kb_rdn;
        @(posedge clk);
        #1;
        if (rdn_low && q.size() != 0) begin
            dummy = q.pop_front();
            pulses++;
        end
        refresh();
    endtask

    task automatic wait_ev(input string tag);
        for (int i = 0; i < 20 && !ev_valid; i++) tick();
        chk(tag, ev_valid, 1);
    endtask

    task automatic ack();
        ev_ack = 1'b1;
        tick();
        ev_ack = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_rdn", kb_rdn, 1);
        chk("rst_valid", ev_valid, 0);
        chk("rst_code", ev_code, 0);
        chk("rst_mods", mods, 0);
        chk("rst_err", err, 0);
        clrn = 1'b1;
        tick();
        // Single make with backpressure while held.
        push(8'h1C);
        tick();
        chk("t1_pulse", pulses, 1);
        chk("t1_valid", ev_valid, 1);
        chk("t1_code", ev_code, 8'h1C);
        chk("t1_brk", ev_brk, 0);
        chk("t1_ext", ev_ext, 0);
        push(8'h00);
        repeat (5) tick();
        chk("t1_bp_pulse", pulses, 1);
        chk("t1_bp_valid", ev_valid, 1);
        ack();
        chk("t1_ack_pulse", pulses, 1);
        chk("t1_ack_valid", ev_valid, 0);
        tick();
        chk("t1_drop_pulse", pulses, 2);
        chk("t1_drop_valid", ev_valid, 0);
        // Extended break.
        p0 = pulses;
        push(8'hE0); push(8'hF0); push(8'h75);
        wait_ev("t2_valid");
        chk("t2_pulses", pulses - p0, 3);
        chk("t2_code", ev_code, 8'h75);
        chk("t2_brk", ev_brk, 1);
        chk("t2_ext", ev_ext, 1);
        chk("t2_mods", mods, 0);
        ack();
        // Modifiers.
        push(8'h12); wait_ev("t3a_valid");
        chk("t3a_mods", mods, 4'b0001);
        ack();
        push(8'h58); wait_ev("t3b_valid");
        chk("t3b_mods", mods, 4'b1001);
        ack();
        push(8'hF0); push(8'h12); wait_ev("t3c_valid");
        chk("t3c_brk", ev_brk, 1);
        chk("t3c_mods", mods, 4'b1000);
        ack();
        // Timeout after E0.
        push(8'hE0);
        tick();
        repeat (90) tick();
        chk("t4_err_early", err, 0);
        repeat (20) tick();
        chk("t4_err", err, 1);
        chk("t4_noev", ev_valid, 0);
        push(8'h1C); wait_ev("t4_valid");
        chk("t4_code", ev_code, 8'h1C);
        chk("t4_ext", ev_ext, 0);
        ack();
        chk("t4_err_sticky", err, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t4_err_clr", err, 0);
        // Overflow, and set winning over clear.
        kb_overflow = 1'b1; tick(); kb_overflow = 1'b0;
        chk("ov_err", err, 1);
        kb_overflow = 1'b1; err_clr = 1'b1; tick(); kb_overflow = 1'b0;
        chk("ov_set_wins", err, 1);
        tick(); err_clr = 1'b0;
        chk("ov_clr", err, 0);
        // F0 F0 is a broken sequence.
        push(8'hF0); push(8'hF0);
        repeat (4) tick();
        chk("bad_err", err, 1);
        chk("bad_noev", ev_valid, 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        // Reset with an event pending, then again inside a break sequence.
        push(8'h11); wait_ev("r_valid");
        chk("r_mods", mods, 4'b1100);
        push(8'hF0);
        clrn = 1'b0;
        #1;
        chk("r_async_valid", ev_valid, 0);
        chk("r_async_mods", mods, 0);
        chk("r_async_rdn", kb_rdn, 1);
        tick();
        clrn = 1'b1;
        tick();
        chk("r_f0_taken", q.size(), 0);
        clrn = 1'b0;
        #1;
        chk("r2_valid", ev_valid, 0);
        tick();
        clrn = 1'b1;
        push(8'h2A); wait_ev("r2_ev");
        chk("r2_code", ev_code, 8'h2A);
        chk("r2_brk", ev_brk, 0);
        ack();
        // Typematic repeats.
        push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
        n = 0;
        last_brk = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ev_valid) begin
                n++;
                last_brk = ev_brk;
                ack();
            end else tick();
        end
`ifdef KBD_REPEAT_FILTER_EN
        chk("rep_events", n, 2);
`else
        chk("rep_events", n, 4);
`endif
        chk("rep_last_brk", last_brk, 1);
        chk("rep_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
